serial_frame_serializer: RTL
============================

Name: serial_frame_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the 1001 Moore sequence detector and drives its serial `din` input.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Shifts each word out one bit per clock, MSB first by default, with a qualifying valid strobe.
- Optionally inserts a programmable idle gap between words so detector behaviour across word boundaries is controllable.

Parameters:
- WIDTH, 8, word width in bits (≥2).
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.
- GAP_CYCLES, 0, idle cycles inserted after each word (0 = back-to-back capable).
- IDLE_LEVEL, 0, value driven on dout when no bit is being sent.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous assertion, active-low (0 = reset).
- din_data  input  WIDTH  parallel word to send.
- din_valid  input  1  din_data is valid.
- din_ready  output  1  block will accept din_data on this edge.
- dout  output  1  serial bit; feeds detector din.
- dout_valid  output  1  dout carries a data bit this cycle.
- busy  output  1  SHIFT or GAP state active.
- word_done  output  1  one-cycle pulse in the cycle the last bit of a word is on dout.

Behaviour:
- States: IDLE, SHIFT, GAP, held in a registered state variable.
- Reset (rst=0, async): state=IDLE, shift reg=0, bit_cnt=0, gap_cnt=0, dout=IDLE_LEVEL, dout_valid=0, word_done=0, busy=0. din_ready is forced 0 while rst=0.
- Reset mid-word: the word in flight is discarded, no partial completion and no word_done. The first edge after release is in IDLE.
- Handshake: transfer occurs on a rising edge with din_valid=1 and din_ready=1. din_data is ignored when din_ready=0. A held din_valid is not consumed twice.
- din_ready is combinational: 1 in IDLE. Also 1 in SHIFT when bit_cnt==WIDTH-1 and GAP_CYCLES==0 (back-to-back). Otherwise 0.
- Accept at edge k:
  - shift reg loaded, bit_cnt=0, state=SHIFT.
  - First bit is on dout with dout_valid=1 during cycle k+1 (latency 1 cycle from accept).
  - dout and dout_valid are registered outputs.
- SHIFT:
  - Each edge advances one bit and increments bit_cnt.
  - The word occupies exactly WIDTH consecutive dout_valid cycles.
  - word_done=1 during the cycle the final bit is on dout.
- End of word:
  - GAP_CYCLES>0: next state is GAP.
  - Else, if a transfer occurs on that same edge: reload and stay in SHIFT, no bubble.
  - Else: IDLE.
- GAP: dout=IDLE_LEVEL and dout_valid=0 for exactly GAP_CYCLES cycles, then IDLE. din_ready=0 throughout GAP.
- IDLE: dout=IDLE_LEVEL, dout_valid=0.
- Counters: bit_cnt width is clog2(WIDTH); gap_cnt width is clog2(GAP_CYCLES+1), min 1. No wrap beyond terminal count; terminal compare is exact.
- Bit order: MSB_FIRST=0 shifts right and emits the LSB first; otherwise the shift reg shifts left and emits the MSB.
- Illegal state encodings recover to IDLE on the next edge with outputs at idle values.

Decomposition:
- Shared package serial_pkg:
  - state enum typedef {IDLE, SHIFT, GAP}
  - default WIDTH constant
  - clog2-based width helper
- Single module. The bit/gap counting is simple enough that no sub-module is warranted.
- Optional reusable sub-module: down_counter (load, dec, zero flag), shared by bit_cnt and gap_cnt.

Test Plan:
- Reset: hold rst=0 for 3 cycles with din_valid=1 → din_ready=0, dout=0, dout_valid=0. Release, then send 8'h99 → dout sequence 1,0,0,1,1,0,0,1 over cycles k+1..k+8. word_done only in cycle k+8.
- Back-to-back (GAP_CYCLES=0): din_valid held with 8'hA5 then 8'h3C → 16 contiguous dout_valid cycles emitting 10100101 00111100. din_ready=1 in the last-bit cycle of the first word.
- Gap (GAP_CYCLES=3): two words 8'h81 → after the 8th bit, 3 cycles of dout_valid=0 and din_ready=0, then IDLE. Second word starts 1 cycle after its accept.
- LSB-first (MSB_FIRST=0): 8'h01 → dout 1,0,0,0,0,0,0,0.
- Async reset mid-word: drop rst at bit 4 of 8'hFF, between edges → dout=0 and dout_valid=0 immediately. No word_done. After release, the next accepted word 8'h90 is emitted cleanly as 10010000.
- Stall: din_valid=1 with data changing while busy (din_ready=0) → only the value present at a ready edge is transmitted. No duplicate or lost words.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial frame serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_pkg;

  // Default parallel word width.
  localparam int SER_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Plain 2-bit constants so the FSM register can be a simple logic vector
  // and still decode the unused encoding (2'b11) in a default branch.
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_GAP   = GAP;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_frame_serializer.sv
// Purpose: parallel-to-serial stage feeding a serial sequence detector; one bit per clock,
//          MSB or LSB first, optional idle gap between words.
// Latency: first bit on dout one cycle after the accepting edge; WIDTH valid cycles per word.
// Backpressure: din_ready high in IDLE, and on the last bit of a word when no gap is configured.
// Ports:
//   clk, rst (async, active-low)
//   din_data/din_valid/din_ready : word input handshake
//   dout/dout_valid              : registered serial bit and its qualifier
//   busy                         : SHIFT or GAP active
//   word_done                    : pulse while the final bit of a word is on dout
module serial_frame_serializer
  import serial_pkg::*;
#(
  parameter int          WIDTH      = SER_WIDTH_DEF,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_data,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(int'(GAP_CYCLES) + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             word_done_q, word_done_d;
  logic             accept;

  // Ready is held low during reset even though the state reads IDLE.
  assign din_ready = rst & ((state_q == ST_IDLE) |
                            ((GAP_CYCLES == 0) && (state_q == ST_SHIFT) &&
                             (bit_cnt_q == BIT_LAST)));
  assign accept    = din_valid & din_ready;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    dout_d       = IDLE_LEVEL;
    dout_valid_d = 1'b0;
    word_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          shreg_d   = din_data;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else if (accept) begin
            // Back-to-back reload: the next word's first bit follows with no bubble.
            shreg_d = din_data;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
        gap_cnt_d = '0;
      end
    endcase

    // Output bit is taken from the next shift-register value so dout is a
    // pure register yet carries the first bit in the cycle after accept.
    if (state_d == ST_SHIFT) begin
      dout_d       = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
      dout_valid_d = 1'b1;
      word_done_d  = (bit_cnt_d == BIT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      dout_q       <= IDLE_LEVEL;
      dout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      word_done_q  <= word_done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign word_done  = word_done_q;
  assign busy       = (state_q == ST_SHIFT) | (state_q == ST_GAP);

endmodule
